instr_loader: RTL and testbench

- Writer side of the instruction-memory interface: the pipelined CPU only reads instruction memory, and this block fills it.
- Receives a byte stream through a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word to consecutive word addresses through the instruction RAM write port.
- Holds the CPU stalled until the end-of-program word has been written or memory is full.

---
 rtl/instr_loader_pkg.sv | 21 ++
 rtl/instr_loader_byte_assembler.sv | 38 +++
 rtl/instr_loader.sv | 117 +++++++++++
 tb/tb_instr_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// The instruction-memory geometry constants are also used by the CPU top
// level and the instruction RAM, so the three blocks agree on the depth.
// Contents:
//   state_t           loader FSM encoding (LOAD, WRITE, DONE)
//   IMEM_ADDR_WIDTH   default word-address width of instruction memory
//   IMEM_DEPTH        default instruction memory depth in words
//   END_WORD_DEFAULT  default end-of-program marker word
package instr_loader_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int          IMEM_ADDR_WIDTH  = 9;
    localparam int          IMEM_DEPTH       = 1 << IMEM_ADDR_WIDTH;
    localparam logic [31:0] END_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// Packs a stream of bytes into a big-endian 32-bit word.
// The first byte of a word ends up in bits 31:24 and the fourth in bits 7:0.
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   accept         a byte is consumed on this edge
//   clear          drop any partial word and restart at byte 0
//   data           incoming byte
//   word           assembled word (registered)
//   word_complete  high in the cycle the 4th byte of a word is accepted
module byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  logic        clear,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [1:0] byte_idx;

    // Shifting left means that after four bytes the first one sits in the top
    // byte lane, which gives big-endian order without decoding the index.
    // The index wraps 3 -> 0 on its own once the 4th byte is taken.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_idx <= 2'd0;
            word     <= 32'd0;
        end else if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            word     <= {word[23:0], data};
        end
    end

    assign word_complete = accept && (byte_idx == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// Writer side of the instruction-memory interface.
// Collects bytes over a valid/ready handshake, assembles big-endian words,
// writes them to consecutive instruction RAM addresses and keeps the CPU
// frozen until the end-of-program marker is written or memory is full.
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle pulse; restarts a load from DONE only
//   in_valid    in_data holds a valid byte
//   in_data     stream byte
//   in_ready    a byte is accepted this cycle when in_valid is also high
//   ram_we      instruction RAM write enable
//   ram_addr    instruction RAM word address
//   ram_wdata   instruction RAM write data
//   cpu_hold    freezes CPU PC and pipeline while high
//   done        load finished
//   overflow    memory filled before the end marker arrived
//   word_count  words written in this load, end marker included
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter logic [31:0] END_WORD   = END_WORD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count
);

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        restart;
    logic        word_complete;
    logic        last_addr;
    logic        is_end;
    logic [31:0] word;

    assign accept    = in_valid && in_ready;
    assign restart   = (state == DONE) && start;
    assign last_addr = (ram_addr == {ADDR_WIDTH{1'b1}});
    assign is_end    = (word == END_WORD);

    byte_assembler u_byte_assembler (
        .clk           (clk),
        .rst           (rst),
        .accept        (accept),
        .clear         (restart),
        .data          (in_data),
        .word          (word),
        .word_complete (word_complete)
    );

    // The assembler register already holds the finished word during WRITE.
    assign ram_wdata = word;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            LOAD:    if (word_complete) next_state = WRITE;
            WRITE:   if (is_end || last_addr) next_state = DONE;
                     else next_state = LOAD;
            DONE:    if (start) next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        in_ready = (state == LOAD);
        ram_we   = (state == WRITE);
        cpu_hold = (state != DONE);
    end

    // Address counter and status flags. The end marker takes priority over
    // the full-memory check, so a marker in the last slot is not an overflow.
    // The address is held on the last slot so it never wraps within a load.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            ram_addr   <= '0;
            word_count <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else if (state == WRITE) begin
            word_count <= word_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
            if (is_end) begin
                done <= 1'b1;
            end else if (last_addr) begin
                done     <= 1'b1;
                overflow <= 1'b1;
            end else begin
                ram_addr <= ram_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: one instance with the default 512-word
// memory and one with a 4-word memory for the full-memory cases. Both share
// the stimulus; a small write-capture model records what each RAM would hold.
module tb_instr_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       use2 = 1'b0;
    logic       clr_mem = 1'b0;

    logic        rdy9, we9, hold9, done9, ovf9;
    logic [8:0]  addr9;
    logic [31:0] wd9;
    logic [9:0]  wc9;

    logic        rdy2, we2, hold2, done2, ovf2;
    logic [1:0]  addr2;
    logic [31:0] wd2;
    logic [2:0]  wc2;

    int tests = 0;
    int fails = 0;
    int wr9 = 0;
    int wr2 = 0;
    int base;

    logic [31:0] mem9 [0:511];
    logic [31:0] mem2 [0:3];

    instr_loader dut9 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy9), .ram_we(we9), .ram_addr(addr9), .ram_wdata(wd9),
        .cpu_hold(hold9), .done(done9), .overflow(ovf9), .word_count(wc9)
    );

    instr_loader #(.ADDR_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy2), .ram_we(we2), .ram_addr(addr2), .ram_wdata(wd2),
        .cpu_hold(hold2), .done(done2), .overflow(ovf2), .word_count(wc2)
    );

    // RAM write-port models
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 512; i++) mem9[i] <= 32'h0;
            for (int i = 0; i < 4; i++) mem2[i] <= 32'h0;
        end else begin
            if (we9) begin
                mem9[addr9] <= wd9;
                wr9 <= wr9 + 1;
            end
            if (we2) begin
                mem2[addr2] <= wd2;
                wr2 <= wr2 + 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        while (!(use2 ? rdy2 : rdy9) && n < 16) begin
            tick;
            n++;
        end
        if (n >= 16) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: waited %0d cycles, limit 16", n);
        end
        in_valid = 1'b1;
        in_data  = b;
        tick;
        in_valid = 1'b0;
        in_data  = 8'h5A;
        if (gap) tick;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic clear_mem;
        clr_mem = 1'b1;
        tick;
        clr_mem = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        tick;
        tick;
        chk("rst_in_ready", rdy9, 1);
        chk("rst_cpu_hold", hold9, 1);
        chk("rst_ram_we", we9, 0);
        chk("rst_done", done9, 0);
        chk("rst_overflow", ovf9, 0);
        chk("rst_word_count", wc9, 0);
        chk("rst_ram_addr", addr9, 0);
        chk("rst_ram_wdata", wd9, 0);
        rst = 1'b0;
        clear_mem;

        // Back-to-back stream: 00000008 then end marker
        base = wr9;
        send_word(32'h0000_0008, 1'b0);
        chk("t1_w0_we", we9, 1);
        chk("t1_w0_addr", addr9, 0);
        chk("t1_w0_data", wd9, 32'h0000_0008);
        chk("t1_w0_ready", rdy9, 0);
        send_word(32'hFFFF_FFFF, 1'b0);
        chk("t1_w1_we", we9, 1);
        chk("t1_w1_addr", addr9, 1);
        chk("t1_w1_data", wd9, 32'hFFFF_FFFF);
        chk("t1_w1_hold", hold9, 1);
        tick;
        chk("t1_done", done9, 1);
        chk("t1_overflow", ovf9, 0);
        chk("t1_word_count", wc9, 2);
        chk("t1_hold_fall", hold9, 0);
        chk("t1_mem0", mem9[0], 32'h0000_0008);
        chk("t1_mem1", mem9[1], 32'hFFFF_FFFF);
        chk("t1_writes", wr9 - base, 2);
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick;
        in_valid = 1'b0;
        chk("t1_done_ready", rdy9, 0);
        chk("t1_done_count", wc9, 2);

        // Same stream with in_valid toggling every cycle
        clear_mem;
        pulse_start;
        chk("t2_hold_rise", hold9, 1);
        chk("t2_count_clr", wc9, 0);
        chk("t2_done_clr", done9, 0);
        base = wr9;
        send_byte(8'h00, 1'b1);
        chk("t2_gap_ready", rdy9, 1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h08, 1'b1);
        send_word(32'hFFFF_FFFF, 1'b1);
        chk("t2_done", done9, 1);
        chk("t2_mem0", mem9[0], 32'h0000_0008);
        chk("t2_mem1", mem9[1], 32'hFFFF_FFFF);
        chk("t2_writes", wr9 - base, 2);
        chk("t2_word_count", wc9, 2);

        // Reset in the middle of a word discards the partial bytes
        clear_mem;
        pulse_start;
        base = wr9;
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        send_word(32'hAABB_CCDD, 1'b0);
        chk("t3_we", we9, 1);
        chk("t3_addr", addr9, 0);
        chk("t3_data", wd9, 32'hAABB_CCDD);
        chk("t3_no_early_write", wr9 - base, 0);
        send_word(32'hFFFF_FFFF, 1'b0);
        tick;
        chk("t3_mem0", mem9[0], 32'hAABB_CCDD);
        chk("t3_writes", wr9 - base, 2);
        chk("t3_done", done9, 1);

        // Restart from DONE; a start pulse mid-word in LOAD is ignored
        clear_mem;
        pulse_start;
        chk("t6_hold_rise", hold9, 1);
        chk("t6_count_clr", wc9, 0);
        send_word(32'h1122_3344, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        pulse_start;
        chk("t6_addr_kept", addr9, 1);
        chk("t6_hold_kept", hold9, 1);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        chk("t6_we", we9, 1);
        chk("t6_addr", addr9, 1);
        chk("t6_data", wd9, 32'hFFFF_FFFF);
        tick;
        chk("t6_done", done9, 1);
        chk("t6_word_count", wc9, 2);
        chk("t6_mem0", mem9[0], 32'h1122_3344);

        // 4-word memory: fill without an end marker
        use2 = 1'b1;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        clear_mem;
        base = wr2;
        send_word(32'h1, 1'b0);
        send_word(32'h2, 1'b0);
        send_word(32'h3, 1'b0);
        send_word(32'h4, 1'b0);
        chk("t4_last_addr", addr2, 3);
        tick;
        chk("t4_done", done2, 1);
        chk("t4_overflow", ovf2, 1);
        chk("t4_word_count", wc2, 4);
        chk("t4_addr_nowrap", addr2, 3);
        chk("t4_mem0", mem2[0], 32'h1);
        chk("t4_mem3", mem2[3], 32'h4);
        chk("t4_writes", wr2 - base, 4);
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick;
        chk("t4_fifth_ready", rdy2, 0);
        chk("t4_fifth_count", wc2, 4);
        tick;
        in_valid = 1'b0;
        chk("t4_fifth_writes", wr2 - base, 4);

        // 4-word memory: end marker in the last slot is not an overflow;
        // a word starting with FF FF FF does not terminate early
        rst = 1'b1;
        tick;
        rst = 1'b0;
        clear_mem;
        send_word(32'h1, 1'b0);
        send_word(32'hFFFF_FF00, 1'b0);
        send_word(32'h3, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        tick;
        chk("t5_done", done2, 1);
        chk("t5_overflow", ovf2, 0);
        chk("t5_word_count", wc2, 4);
        chk("t5_mem1", mem2[1], 32'hFFFF_FF00);
        chk("t5_mem3", mem2[3], 32'hFFFF_FFFF);

        // rst and start together: reset wins, loader back in LOAD with flags clear
        rst   = 1'b1;
        start = 1'b1;
        tick;
        rst   = 1'b0;
        start = 1'b0;
        chk("rs_done", done2, 0);
        chk("rs_hold", hold2, 1);
        chk("rs_count", wc2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
